// File: rtl/norm_float_to_fixed_mc.sv
// Multi-channel IEEE-754 single to signed Q(FW-FRAC).FRAC converter sharing one datapath via round-robin.
// Define NORM_ROUND_EN for round-to-nearest (ties away) on right shifts; otherwise the magnitude truncates.
module norm_float_to_fixed_mc #(
    parameter int CH   = 2,
    parameter int FW   = 32,
    parameter int FRAC = 24
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [CH*32-1:0] F,
    input  logic [CH-1:0]    Begin_FSM,
    output logic [CH-1:0]    ACK,
    output logic [CH*FW-1:0] RESULT,
    output logic [CH-1:0]    O_F,
    output logic [CH-1:0]    U_F,
    output logic             BUSY
);

    localparam int PW = (CH > 1) ? $clog2(CH) : 1;
    localparam int MW = FW + 1;
    localparam logic [MW-1:0] MAX_POS     = {2'b00, {(FW-1){1'b1}}};
    localparam logic [MW-1:0] MAX_NEG_MAG = {2'b01, {(FW-1){1'b0}}};
    localparam logic [FW-1:0] SAT_POS     = {1'b0, {(FW-1){1'b1}}};
    localparam logic [FW-1:0] SAT_NEG     = {1'b1, {(FW-1){1'b0}}};
`ifdef NORM_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, ALIGN, FIX, DONE} state_t;

    state_t          state;
    logic [31:0]     hold [CH];
    logic [CH-1:0]   pending;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   grant;
    logic            sign_r;
    logic [7:0]      exp_r;
    logic [22:0]     mant_r;
    logic [MW-1:0]   mag_r;
    logic            round_r;
    logic            big_r;
    logic [FW-1:0]   fix_res;
    logic            fix_of;
    logic            fix_uf;

    logic [PW-1:0]   sel;
    logic [PW-1:0]   cand;
    logic            found;
    logic [CH-1:0]   clr;
    int              shift;
    logic [24:0]     wide;
    logic [MW-1:0]   al_mag;
    logic            al_round;
    logic            al_big;
    logic [MW-1:0]   sum;
    logic [FW-1:0]   f_res;
    logic            f_of;
    logic            f_uf;

    // Round-robin: first pending channel at or after the pointer.
    always_comb begin
        sel   = '0;
        cand  = '0;
        found = 1'b0;
        for (int j = 0; j < CH; j++) begin
            cand = PW'((int'(ptr) + j) % CH);
            if (!found && pending[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        clr = '0;
        if (state == LOAD && found) clr[sel] = 1'b1;
    end

    // The extra low bit of the right-shift window is the half-LSB used for rounding.
    always_comb begin
        shift    = int'(exp_r) - 150 + FRAC;
        wide     = '0;
        al_mag   = '0;
        al_round = 1'b0;
        al_big   = 1'b0;
        if (shift >= 0) begin
            if (shift > FW - 23) al_big = 1'b1;
            else                 al_mag = MW'({1'b1, mant_r}) << shift;
        end else begin
            wide     = {1'b1, mant_r, 1'b0} >> (-shift);
            al_mag   = MW'(wide[24:1]);
            al_round = wide[0];
        end
    end

    always_comb begin
        sum   = mag_r + MW'(round_r && ROUND_EN);
        f_res = '0;
        f_of  = 1'b0;
        f_uf  = 1'b0;
        if (exp_r == 8'd0) begin
            f_uf = (mant_r != 23'd0);
        end else if (exp_r == 8'hFF) begin
            f_of  = 1'b1;
            f_res = (sign_r && mant_r == 23'd0) ? SAT_NEG : SAT_POS;
        end else if (big_r || sum > (sign_r ? MAX_NEG_MAG : MAX_POS)) begin
            f_of  = 1'b1;
            f_res = sign_r ? SAT_NEG : SAT_POS;
        end else begin
            f_res = sign_r ? -sum[FW-1:0] : sum[FW-1:0];
            f_uf  = (sum == '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= IDLE;
            pending <= '0;
            ptr     <= '0;
            grant   <= '0;
            sign_r  <= 1'b0;
            exp_r   <= '0;
            mant_r  <= '0;
            mag_r   <= '0;
            round_r <= 1'b0;
            big_r   <= 1'b0;
            fix_res <= '0;
            fix_of  <= 1'b0;
            fix_uf  <= 1'b0;
            ACK     <= '0;
            RESULT  <= '0;
            O_F     <= '0;
            U_F     <= '0;
            BUSY    <= 1'b0;
            for (int i = 0; i < CH; i++) hold[i] <= '0;
        end else begin
            ACK <= '0;
            for (int i = 0; i < CH; i++) begin
                if (Begin_FSM[i]) hold[i] <= F[32*i +: 32];
            end
            pending <= (pending & ~clr) | Begin_FSM;

            case (state)
                IDLE: begin
                    if (|(pending | Begin_FSM)) begin
                        state <= LOAD;
                        BUSY  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (found) begin
                        grant                    <= sel;
                        {sign_r, exp_r, mant_r}  <= hold[sel];
                        ptr                      <= (int'(sel) == CH - 1) ? '0 : sel + 1'b1;
                        state                    <= ALIGN;
                    end else begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                ALIGN: begin
                    mag_r   <= al_mag;
                    round_r <= al_round;
                    big_r   <= al_big;
                    state   <= FIX;
                end
                FIX: begin
                    fix_res <= f_res;
                    fix_of  <= f_of;
                    fix_uf  <= f_uf;
                    state   <= DONE;
                end
                DONE: begin
                    RESULT[int'(grant)*FW +: FW] <= fix_res;
                    O_F[grant]                   <= fix_of;
                    U_F[grant]                   <= fix_uf;
                    ACK[grant]                   <= 1'b1;
                    state                        <= IDLE;
                    BUSY                         <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_norm_float_to_fixed_mc.sv
// Directed-vector bench for norm_float_to_fixed_mc (CH=2, Q8.24); expectations follow NORM_ROUND_EN.
module tb_norm_float_to_fixed_mc;

    localparam int CH = 2;
    localparam int FW = 32;
`ifdef NORM_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST_N;
    logic [CH*32-1:0] F;
    logic [CH-1:0]    Begin_FSM;
    logic [CH-1:0]    ACK;
    logic [CH*FW-1:0] RESULT;
    logic [CH-1:0]    O_F;
    logic [CH-1:0]    U_F;
    logic             BUSY;

    int compared   = 0;
    int mismatched = 0;

    int            ackFirst [CH];
    int            ackLast  [CH];
    int            ackCount [CH];
    logic [FW-1:0] resFirst [CH];
    logic [FW-1:0] resLast  [CH];
    logic          ofFirst  [CH];
    logic          ufFirst  [CH];
    int            multiHot;

    norm_float_to_fixed_mc #(.CH(CH), .FW(FW), .FRAC(24)) dut (
        .CLK(CLK), .RST_N(RST_N), .F(F), .Begin_FSM(Begin_FSM),
        .ACK(ACK), .RESULT(RESULT), .O_F(O_F), .U_F(U_F), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Launches Begin on the masked channels at the next rising edge (edge k).
    task automatic applyStimulus(input logic [CH-1:0] mask, input logic [31:0] f0, input logic [31:0] f1);
        @(negedge CLK);
        F         = {f1, f0};
        Begin_FSM = mask;
        @(posedge CLK);
        #1;
        Begin_FSM = '0;
    endtask

    // Observes a bounded window of edges, numbering them from start+1 relative to edge k.
    task automatic runWindow(input int start, input int cycles);
        multiHot = 0;
        for (int c = 0; c < CH; c++) begin
            ackFirst[c] = -1;
            ackLast[c]  = -1;
            ackCount[c] = 0;
        end
        for (int i = start + 1; i <= start + cycles; i++) begin
            @(posedge CLK);
            #1;
            if ($countones(ACK) > 1) multiHot++;
            for (int c = 0; c < CH; c++) begin
                if (ACK[c] === 1'b1) begin
                    if (ackCount[c] == 0) begin
                        ackFirst[c] = i;
                        resFirst[c] = RESULT[c*FW +: FW];
                        ofFirst[c]  = O_F[c];
                        ufFirst[c]  = U_F[c];
                    end
                    ackLast[c] = i;
                    resLast[c] = RESULT[c*FW +: FW];
                    ackCount[c]++;
                end
            end
        end
    endtask

    task automatic singleConv(input string tag, input int ch, input logic [31:0] f,
                              input logic [31:0] expRes, input logic expOf, input logic expUf);
        logic [CH-1:0] mask;
        mask = CH'(1 << ch);
        applyStimulus(mask, (ch == 0) ? f : 32'h0, (ch == 1) ? f : 32'h0);
        runWindow(0, 14);
        checkOutput({tag, "_lat"},   64'(ackFirst[ch]), 64'd4);
        checkOutput({tag, "_cnt"},   64'(ackCount[ch]), 64'd1);
        checkOutput({tag, "_other"}, 64'(ackCount[1-ch]), 64'd0);
        checkOutput({tag, "_res"},   64'(resFirst[ch]), 64'(expRes));
        checkOutput({tag, "_of"},    64'(ofFirst[ch]), 64'(expOf));
        checkOutput({tag, "_uf"},    64'(ufFirst[ch]), 64'(expUf));
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_ack"},  64'(ACK), 64'd0);
        checkOutput({tag, "_res"},  64'(RESULT), 64'd0);
        checkOutput({tag, "_of"},   64'(O_F), 64'd0);
        checkOutput({tag, "_uf"},   64'(U_F), 64'd0);
        checkOutput({tag, "_busy"}, 64'(BUSY), 64'd0);
    endtask

    initial begin
        RST_N     = 1'b0;
        F         = '0;
        Begin_FSM = '0;
        repeat (3) @(posedge CLK);
        #1;
        checkIdleOutputs("reset");
        RST_N = 1'b1;

        singleConv("one",    0, 32'h3F800000, 32'h01000000, 1'b0, 1'b0);
        singleConv("m2p5",   0, 32'hC0200000, 32'hFD800000, 1'b0, 1'b0);
        singleConv("p0p75",  0, 32'h3F400000, 32'h00C00000, 1'b0, 1'b0);
        singleConv("p200",   1, 32'h43480000, 32'h7FFFFFFF, 1'b1, 1'b0);
        singleConv("ninf",   1, 32'hFF800000, 32'h80000000, 1'b1, 1'b0);
        singleConv("nnan",   1, 32'hFFC00000, 32'h7FFFFFFF, 1'b1, 1'b0);
        singleConv("m128",   1, 32'hC3000000, 32'h80000000, 1'b0, 1'b0);
        singleConv("tiny",   0, 32'h33000000, ROUND ? 32'h1 : 32'h0, 1'b0, !ROUND);
        singleConv("tie",    0, 32'h33C00000, ROUND ? 32'h2 : 32'h1, 1'b0, 1'b0);
        singleConv("denorm", 1, 32'h00000001, 32'h0, 1'b0, 1'b1);

        // Pointer sits at ch0 here, so ch0 goes first.
        applyStimulus(2'b11, 32'h3F800000, 32'hC0200000);
        runWindow(0, 14);
        checkOutput("pair1_lat0",  64'(ackFirst[0]), 64'd4);
        checkOutput("pair1_lat1",  64'(ackFirst[1]), 64'd9);
        checkOutput("pair1_res0",  64'(resFirst[0]), 64'h01000000);
        checkOutput("pair1_res1",  64'(resFirst[1]), 64'hFD800000);
        checkOutput("pair1_cnt",   64'(ackCount[0] + ackCount[1]), 64'd2);
        checkOutput("pair1_multi", 64'(multiHot), 64'd0);

        // A lone ch0 request moves the pointer to ch1, so the next pair is served ch1 first.
        singleConv("alt_pre", 0, 32'h3F400000, 32'h00C00000, 1'b0, 1'b0);
        applyStimulus(2'b11, 32'h3F800000, 32'h43480000);
        runWindow(0, 14);
        checkOutput("pair2_lat1",  64'(ackFirst[1]), 64'd4);
        checkOutput("pair2_lat0",  64'(ackFirst[0]), 64'd9);
        checkOutput("pair2_res1",  64'(resFirst[1]), 64'h7FFFFFFF);
        checkOutput("pair2_of1",   64'(ofFirst[1]), 64'd1);
        checkOutput("pair2_res0",  64'(resFirst[0]), 64'h01000000);
        checkOutput("pair2_multi", 64'(multiHot), 64'd0);

        // Re-arm ch0 at edge k+2 while its first conversion is in flight.
        applyStimulus(2'b01, 32'h3F800000, 32'h0);
        @(posedge CLK);
        #1;
        F[31:0]   = 32'hC0200000;
        Begin_FSM = 2'b01;
        @(posedge CLK);
        #1;
        Begin_FSM = '0;
        runWindow(2, 14);
        checkOutput("rearm_lat1", 64'(ackFirst[0]), 64'd4);
        checkOutput("rearm_res1", 64'(resFirst[0]), 64'h01000000);
        checkOutput("rearm_lat2", 64'(ackLast[0]), 64'd9);
        checkOutput("rearm_res2", 64'(resLast[0]), 64'hFD800000);
        checkOutput("rearm_cnt",  64'(ackCount[0]), 64'd2);

        // Reset at edge k+2 discards the conversion and clears every output.
        applyStimulus(2'b01, 32'h3F800000, 32'h0);
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        checkIdleOutputs("midrst");
        RST_N = 1'b1;
        runWindow(2, 10);
        checkOutput("midrst_noack", 64'(ackCount[0] + ackCount[1]), 64'd0);
        singleConv("post_rst", 0, 32'hC0200000, 32'hFD800000, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/norm_float_to_fixed_mc.md
# norm_float_to_fixed_mc

Multi-channel IEEE-754 single-precision to signed fixed-point normalizer. It is the parametrised successor of the per-signal float-to-fixed converters in the current/voltage acquisition path. CH request channels share one converter through a round-robin arbiter. Each channel has its own Begin/ACK handshake, operand hold register, result register and overflow/underflow flags.

## Interface
- CH, 2, number of channels (1..8)
- FW, 32, fixed-point result width
- FRAC, 24, fractional bits of the result (Q(FW-FRAC).FRAC, two's complement)

Ports:
- CLK  in  1  system clock
- RST_N  in  1  reset, synchronous, active-low
- F  in  CH*32  float operands; channel i at [32*i+31:32*i]
- Begin_FSM  in  CH  per-channel start pulse
- ACK  out  CH  per-channel one-cycle completion pulse
- RESULT  out  CH*FW  per-channel fixed result; channel i at [FW*i+FW-1:FW*i]
- O_F  out  CH  per-channel overflow/saturation flag
- U_F  out  CH  per-channel underflow flag
- BUSY  out  1  high whenever the FSM is not IDLE

## Operation
- Reset (RST_N low at an edge) clears the following to 0: ACK, RESULT, O_F, U_F, BUSY, pending bits, hold registers and the FSM. The round-robin pointer resets to ch0. A conversion in flight is discarded without an ACK.
- Begin_FSM[i]=1 at an edge latches F[i] into hold[i] and sets pending[i]. A repeat Begin while pending overwrites hold[i]; the request is not queued twice. A Begin on the channel being converted re-arms pending[i] with the new operand.
- FSM states: IDLE, LOAD, ALIGN, FIX, DONE.
  - IDLE→LOAD when any pending bit is set.
  - LOAD: grant the first pending channel at or after the pointer. Copy hold into the datapath, clear pending[grant], set pointer=grant+1 (mod CH).
  - ALIGN: shift s = exp − 150 + FRAC, applied to M = {1,mant[22:0]}. s≥0 shifts left; s<0 shifts right.
  - FIX: apply the rounding mode, negate if sign=1, then saturate.
  - DONE: write RESULT/O_F/U_F of the grant channel and pulse ACK[grant]. The next state is always IDLE.
- Arithmetic rules:
  - exp=0 (zero or denormal): result 0. U_F=1 if mant≠0.
  - exp=255 (Inf/NaN): O_F=1, result 0x7FFF…F. Negative Inf gives 0x800…0; NaN always gives the positive maximum.
  - Magnitude beyond the representable range saturates to +2^(FW−1)−1 or −2^(FW−1), with O_F=1.
  - U_F=1 when the input is nonzero but the final result is 0.
- O_F and U_F are not sticky. They are rewritten with every RESULT update of that channel. Other channels' outputs hold.

## Timing
- Begin at edge k with the FSM idle and no other pending channel: LOAD at k+1, ALIGN at k+2, FIX at k+3, DONE at k+4. ACK is high for the cycle after edge k+4, and RESULT is valid from that same cycle.
- Each conversion occupies 5 cycles (DONE→IDLE→LOAD). A second granted channel therefore reaches DONE at k+9.
- Simultaneous Begins are all latched in the same cycle. They are served in round-robin order.
- ACK never lasts more than 1 cycle. At most one ACK bit is high per cycle.

## Configuration
- NORM_ROUND_EN defined: bits shifted out on a right shift round to nearest, with ties away from zero. Rounding happens in FIX before negation, and a carry may cause saturation.
- NORM_ROUND_EN undefined: the magnitude is truncated, which rounds toward zero.

## Test plan
- Scalar values, CH=2, ch0:
  - 0x3F800000 (1.0) → RESULT 0x01000000, ACK at k+4, O_F=0, U_F=0.
  - 0xC0200000 (−2.5) → RESULT 0xFD800000.
- Saturation, ch1:
  - 0x43480000 (200.0) → 0x7FFFFFFF, O_F=1.
  - 0xFF800000 (−Inf) → 0x80000000, O_F=1.
- Underflow and rounding:
  - 0x33000000 (2^−25) → without NORM_ROUND_EN: 0x00000000, U_F=1.
  - Same input with NORM_ROUND_EN: 0x00000001, U_F=0.
  - 0x00000001 (denormal) → 0, U_F=1.
- Arbitration: Begin ch0 and ch1 at edge k → ACK[0] at k+4, ACK[1] at k+9. Repeated simultaneous requests alternate the service order.
- Re-arm: a Begin on ch0 at k+2 with a new operand → the first ACK carries the old operand's result, and a second ACK[0] follows at k+9 with the new operand's result.
- Reset mid-operation: RST_N low at k+2 → no ACK, all outputs 0. After release, a fresh Begin completes normally 4 edges later.
